fetch_queue: RTL
================

# fetch_queue

Instruction queue between the fetch stage and the decode stage. Buffers up to DEPTH fetched instruction/PC pairs under a valid/ready handshake. It absorbs decode stalls without stalling instruction-memory reads. It presents the head entry, including the 7-bit opcode, to the decode-stage main decoder. A pipeline redirect (branch/jump taken) discards all buffered entries.

## Interface
- DEPTH, 4: number of entries; power of two, ≥ 2.
- ADDR_WIDTH, 64: PC width.
- INSTR_WIDTH, 32: instruction width.

Reset is asynchronous and active-high; one clock.

- clk  in  1  clock; all state updates on rising edge.
- arst  in  1  asynchronous reset, active-high.
- i_flush  in  1  redirect; empties the queue.
- i_fetch_valid  in  1  fetch presents an instruction.
- i_fetch_instr  in  INSTR_WIDTH  fetched instruction.
- i_fetch_pc  in  ADDR_WIDTH  PC of fetched instruction.
- o_fetch_ready  out  1  queue accepts a push this cycle.
- o_dec_valid  out  1  head entry valid.
- o_dec_instr  out  INSTR_WIDTH  head instruction; NOP when not valid.
- o_dec_op  out  7  o_dec_instr[6:0], routed to the main decoder opcode input.
- o_dec_pc  out  ADDR_WIDTH  head PC; 0 when not valid.
- o_dec_pc_plus4  out  ADDR_WIDTH  o_dec_pc + 4, modulo 2^ADDR_WIDTH.
- i_dec_ready  in  1  decode consumes head this cycle (not stalled).
- o_count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push = i_fetch_valid & o_fetch_ready & !i_flush.
- Pop = o_dec_valid & i_dec_ready & !i_flush.
- Circular storage: write pointer and read pointer of $clog2(DEPTH) bits each, wrapping from DEPTH-1 to 0. Occupancy is held in a separate count register.
- o_fetch_ready = (count != DEPTH).
  - Depends only on registered count, not on i_dec_ready. When full, the queue refuses a push even if a pop occurs in the same cycle.
- o_dec_valid = (count != 0).
- Simultaneous push and pop: both pointers advance and count is unchanged. Legal at any occupancy 1..DEPTH-1.
- Flush: pointers and count go to 0 on the next edge. A push in the same cycle is dropped and a pop in the same cycle is ignored. Flush dominates everything except arst.
- Bubble output (o_dec_valid=0): o_dec_instr = 32'h0000_0013 (addi x0,x0,0), so o_dec_op = 7'b0010011; o_dec_pc = 0. The decoder then sees a harmless I-type ALU op writing x0.
- Storage array is not reset; only pointers and count are reset.
- Reset values: count 0, pointers 0, o_dec_valid 0, o_fetch_ready 1, o_dec_instr NOP, o_dec_op 7'b0010011, o_dec_pc 0, o_dec_pc_plus4 4, o_count 0.
- Reset mid-operation: all entries are lost immediately (asynchronous). No partial pop or push completes.

## Timing
- Default latency is 1 cycle. An entry pushed at edge N is visible on o_dec_* after edge N. No combinational path exists from i_fetch_* to o_dec_*.
- o_fetch_ready and o_dec_valid are functions of registered state only. No combinational path exists from i_dec_ready or i_fetch_valid to either.
- Flush asserted in cycle N: o_dec_valid=0 and o_fetch_ready=1 from cycle N+1.
- Sustained throughput is 1 instruction/cycle when decode never stalls.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count==0 and i_fetch_valid & !i_flush, the fetch inputs are driven combinationally to o_dec_*. In that case o_dec_valid=1 in the same cycle (latency 0).
  - If i_dec_ready is also 1, the entry is consumed without being written and count stays 0.
  - Otherwise it is written normally.
- FETCH_QUEUE_BYPASS_EN undefined: strict 1-cycle latency as in Timing.

## Structure
- Shared package fetch_queue_pkg holds:
  - localparam NOP_INSTR = 32'h0000_0013;
  - typedef struct packed t_fq_entry { instr; pc; };
  - typedef for pointer width derived from DEPTH.
- The pointer/count logic and storage array stay inline. No sub-module: the block is a single FIFO with one read and one write port.

## Test plan
- Reset then idle: o_dec_valid=0, o_dec_op=7'b0010011, o_fetch_ready=1, o_count=0.
- Push 4 instrs (PC 0x1000..0x100C) with i_dec_ready=0 → o_count=4, o_fetch_ready=0; 5th push refused; release i_dec_ready → pops in order 0x1000..0x100C, with o_dec_pc_plus4 = 0x1004..0x1010.
- Continuous push and pop with DEPTH=4, over 20 instrs → in-order output, o_count constant at 1, pointers wrap with no loss or duplication.
- Queue holds 3 entries, i_flush with a simultaneous push and pop → next cycle o_count=0, o_dec_valid=0; the pushed instr never appears.
- arst asserted mid-stream with 2 entries → outputs return to reset values before the next edge; the first push after release appears 1 cycle later.
- With FETCH_QUEUE_BYPASS_EN, empty queue, push 0x00000513 at PC 0x2000 with i_dec_ready=1 → o_dec_valid=1 and o_dec_op=7'b0010011 in the same cycle, o_count stays 0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
// Holds the bubble instruction, the stored entry layout and the
// pointer/occupancy types derived from the default queue depth.
package fetch_queue_pkg;

    localparam int FQ_DEPTH       = 4;
    localparam int FQ_ADDR_WIDTH  = 64;
    localparam int FQ_INSTR_WIDTH = 32;

    // addi x0,x0,0: a harmless I-type ALU op shown to decode on a bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int FQ_PTR_WIDTH = $clog2(FQ_DEPTH);
    localparam int FQ_CNT_WIDTH = FQ_PTR_WIDTH + 1;

    typedef logic [FQ_PTR_WIDTH-1:0] t_fq_ptr;
    typedef logic [FQ_CNT_WIDTH-1:0] t_fq_count;

    typedef struct packed {
        logic [FQ_INSTR_WIDTH-1:0] instr;
        logic [FQ_ADDR_WIDTH-1:0]  pc;
    } t_fq_entry;

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode.
// Buffers up to DEPTH instruction/PC pairs in a circular store with a
// separate occupancy counter, presents the head to the main decoder and
// drops everything on a pipeline redirect (i_flush).
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a fetch straight
// to decode when the queue is empty (zero-cycle latency).
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH       = FQ_DEPTH,
    parameter int ADDR_WIDTH  = FQ_ADDR_WIDTH,
    parameter int INSTR_WIDTH = FQ_INSTR_WIDTH
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     i_flush,
    input  logic                     i_fetch_valid,
    input  logic [INSTR_WIDTH-1:0]   i_fetch_instr,
    input  logic [ADDR_WIDTH-1:0]    i_fetch_pc,
    output logic                     o_fetch_ready,
    output logic                     o_dec_valid,
    output logic [INSTR_WIDTH-1:0]   o_dec_instr,
    output logic [6:0]               o_dec_op,
    output logic [ADDR_WIDTH-1:0]    o_dec_pc,
    output logic [ADDR_WIDTH-1:0]    o_dec_pc_plus4,
    input  logic                     i_dec_ready,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Storage is deliberately not reset; validity comes from count_q alone.
    t_fq_entry        mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             empty;
    logic             full;
    logic             bypass_hit;
    logic             wr_en;
    logic             rd_en;
    t_fq_entry        wr_entry;
    t_fq_entry        head;

    // Handshake decode: which of write/read actually happen this cycle
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL_COUNT);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_hit = empty & i_fetch_valid & ~i_flush;
`else
        bypass_hit = 1'b0;
`endif
        // A bypassed entry that decode takes immediately is never stored
        wr_en = i_fetch_valid & ~full & ~i_flush & ~(bypass_hit & i_dec_ready);
        rd_en = ~empty & i_dec_ready & ~i_flush;
        wr_entry.instr = i_fetch_instr;
        wr_entry.pc    = i_fetch_pc;
    end

    // Next pointer/occupancy; flush overrides any push or pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers, cleared asynchronously
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Single write port into the circular store
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Head presentation: stored head, else bypassed fetch, else a NOP bubble
    always_comb begin
        head          = mem_q[rd_ptr_q];
        o_fetch_ready = ~full;
        o_dec_valid   = ~empty | bypass_hit;
        o_dec_instr   = NOP_INSTR;
        o_dec_pc      = '0;
        if (!empty) begin
            o_dec_instr = head.instr;
            o_dec_pc    = head.pc;
        end else if (bypass_hit) begin
            o_dec_instr = i_fetch_instr;
            o_dec_pc    = i_fetch_pc;
        end
    end

    assign o_dec_op       = o_dec_instr[6:0];
    assign o_dec_pc_plus4 = o_dec_pc + ADDR_WIDTH'(4);
    assign o_count        = count_q;

endmodule
